rv32i_adder_issue_queue: RTL and testbench

//  Data-capture issue queue directly upstream of the 32b adder functional unit.
//  - Accepts dispatched add/sub ops with source operands as values or phys-reg tags.
//  - Captures missing operands from the CDB broadcast.
//  - Issues the oldest fully-ready op into the adder's valid/ready input port.

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/rv32i_isq_oldest_ready_sel.sv | 30 +++
 rtl/rv32i_adder_issue_queue.sv | 156 +++++++++++++++
 tb/tb_rv32i_adder_issue_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i types: phys-reg/ROB widths plus the adder issue-queue entry and CDB structs.
// isq_src_wake() is the single place where an operand captures a matching CDB broadcast.
package rv32i_pkg;

    localparam int PHYS_REG_FILE_IDX_BW = 6;
    localparam int ROB_DEPTH            = 16;
    localparam int ROB_IDX_BW           = $clog2(ROB_DEPTH);
    localparam int ISQ_DEPTH            = 4;

    typedef struct packed {
        logic                            rdy;
        logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
        logic [31:0]                     val;
    } rv32i_isq_src_t;

    typedef struct packed {
        logic                            vld;
        logic                            sub_flag;
        rv32i_isq_src_t                  src1;
        rv32i_isq_src_t                  src2;
        logic [PHYS_REG_FILE_IDX_BW-1:0] dst_tag;
        logic [ROB_IDX_BW-1:0]           rob_idx;
    } rv32i_isq_entry_t;

    typedef struct packed {
        logic                            vld;
        logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
        logic [31:0]                     val;
    } rv32i_cdb_t;

    function automatic rv32i_isq_src_t isq_src_wake(input rv32i_isq_src_t s, input rv32i_cdb_t cdb);
        rv32i_isq_src_t r;
        r = s;
        if (!s.rdy && cdb.vld && (s.tag == cdb.tag)) begin
            r.rdy = 1'b1;
            r.val = cdb.val;
        end
        return r;
    endfunction

endpackage

// File: rtl/rv32i_isq_oldest_ready_sel.sv
// Oldest-ready picker: the lowest set bit of i_req wins (slot 0 is the oldest entry).
// Purely combinational; o_any flags that at least one request is present.
module rv32i_isq_oldest_ready_sel
    import rv32i_pkg::*;
#(
    parameter  int N  = ISQ_DEPTH,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the top down so the lowest requester is the last to overwrite.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_idx    = IW'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/rv32i_adder_issue_queue.sv
// Compacting data-capture issue queue feeding the 32b adder; oldest fully-ready op issues first.
// Optional RV32I_ISQ_CDB_BYPASS_EN lets an op woken by the CDB this cycle issue in the same cycle.
module rv32i_adder_issue_queue
    import rv32i_pkg::*;
#(
    parameter  int DEPTH = ISQ_DEPTH,
    localparam int PRFBW = PHYS_REG_FILE_IDX_BW,
    localparam int ROBW  = ROB_IDX_BW,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_disp_vld,
    output logic             o_disp_rdy,
    input  logic             i_disp_sub_flag,
    input  logic             i_disp_src1_rdy,
    input  logic [PRFBW-1:0] i_disp_src1_tag,
    input  logic [31:0]      i_disp_src1_val,
    input  logic             i_disp_src2_rdy,
    input  logic [PRFBW-1:0] i_disp_src2_tag,
    input  logic [31:0]      i_disp_src2_val,
    input  logic [PRFBW-1:0] i_disp_dst_tag,
    input  logic [ROBW-1:0]  i_disp_rob_idx,
    input  logic             i_cdb_vld,
    input  logic [PRFBW-1:0] i_cdb_tag,
    input  logic [31:0]      i_cdb_val,
    output logic             o_iss_vld,
    input  logic             i_iss_rdy,
    output logic             o_iss_sub_flag,
    output logic [31:0]      o_iss_a,
    output logic [31:0]      o_iss_b,
    output logic [PRFBW-1:0] o_iss_dst_tag,
    output logic [ROBW-1:0]  o_iss_rob_idx,
    output logic [CW-1:0]    o_count
);

    rv32i_isq_entry_t r_q [DEPTH];
    logic [CW-1:0]    r_count;

    rv32i_cdb_t       w_cdb;
    rv32i_isq_entry_t w_woken [DEPTH+1];
    rv32i_isq_entry_t w_nxt [DEPTH];
    rv32i_isq_entry_t w_disp_ent;
    logic [DEPTH-1:0] w_req;
    logic [DEPTH-1:0] w_gnt;
    logic [IW-1:0]    w_sel_idx;
    logic             w_any;
    logic             w_iss_vld;
    logic             w_iss_fire;
    logic             w_disp_rdy;
    logic             w_disp_fire;
    logic [CW-1:0]    w_wr_slot;
    logic             w_sel_sub;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [PRFBW-1:0] w_sel_dst;
    logic [ROBW-1:0]  w_sel_rob;

    assign w_cdb = '{vld: i_cdb_vld, tag: i_cdb_tag, val: i_cdb_val};

    // w_woken is the post-capture view; the extra top slot is an empty filler for compaction.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i]      = r_q[i];
            w_woken[i].src1 = isq_src_wake(r_q[i].src1, w_cdb);
            w_woken[i].src2 = isq_src_wake(r_q[i].src2, w_cdb);
`ifdef RV32I_ISQ_CDB_BYPASS_EN
            w_req[i] = r_q[i].vld & w_woken[i].src1.rdy & w_woken[i].src2.rdy;
`else
            w_req[i] = r_q[i].vld & r_q[i].src1.rdy & r_q[i].src2.rdy;
`endif
        end
        w_woken[DEPTH] = '0;
    end

    rv32i_isq_oldest_ready_sel #(.N(DEPTH)) u_sel (
        .i_req (w_req),
        .o_gnt (w_gnt),
        .o_idx (w_sel_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_sel_sub = 1'b0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_dst = '0;
        w_sel_rob = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_gnt[i]) begin
                w_sel_sub = w_woken[i].sub_flag;
                w_sel_a   = w_woken[i].src1.val;
                w_sel_b   = w_woken[i].src2.val;
                w_sel_dst = w_woken[i].dst_tag;
                w_sel_rob = w_woken[i].rob_idx;
            end
        end
    end

    assign w_iss_vld   = ~rst & ~i_flush & w_any;
    assign w_iss_fire  = w_iss_vld & i_iss_rdy;
    assign w_disp_rdy  = ~rst & (r_count < CW'(DEPTH));
    assign w_disp_fire = i_disp_vld & w_disp_rdy & ~i_flush;
    assign w_wr_slot   = w_iss_fire ? (r_count - 1'b1) : r_count;

    always_comb begin
        w_disp_ent          = '0;
        w_disp_ent.vld      = 1'b1;
        w_disp_ent.sub_flag = i_disp_sub_flag;
        w_disp_ent.src1     = isq_src_wake('{rdy: i_disp_src1_rdy, tag: i_disp_src1_tag,
                                             val: i_disp_src1_val}, w_cdb);
        w_disp_ent.src2     = isq_src_wake('{rdy: i_disp_src2_rdy, tag: i_disp_src2_tag,
                                             val: i_disp_src2_val}, w_cdb);
        w_disp_ent.dst_tag  = i_disp_dst_tag;
        w_disp_ent.rob_idx  = i_disp_rob_idx;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_iss_fire && (IW'(i) >= w_sel_idx)) begin
                w_nxt[i] = w_woken[i+1];
            end else begin
                w_nxt[i] = w_woken[i];
            end
            if (w_disp_fire && (CW'(i) == w_wr_slot)) begin
                w_nxt[i] = w_disp_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nxt[i];
            end
            r_count <= r_count + CW'(w_disp_fire) - CW'(w_iss_fire);
        end
    end

    assign o_disp_rdy     = w_disp_rdy;
    assign o_iss_vld      = w_iss_vld;
    assign o_iss_sub_flag = ~rst & w_sel_sub;
    assign o_iss_a        = rst ? '0 : w_sel_a;
    assign o_iss_b        = rst ? '0 : w_sel_b;
    assign o_iss_dst_tag  = rst ? '0 : w_sel_dst;
    assign o_iss_rob_idx  = rst ? '0 : w_sel_rob;
    assign o_count        = r_count;

endmodule

// File: tb/tb_rv32i_adder_issue_queue.sv
// Directed bench for the adder issue queue: expected issues go into a scoreboard queue,
// a negedge monitor pops and compares every fired issue; timing points are checked inline.
module tb_rv32i_adder_issue_queue;

    logic        clk;
    logic        rst;
    logic        i_flush;
    logic        i_disp_vld;
    logic        o_disp_rdy;
    logic        i_disp_sub_flag;
    logic        i_disp_src1_rdy;
    logic [5:0]  i_disp_src1_tag;
    logic [31:0] i_disp_src1_val;
    logic        i_disp_src2_rdy;
    logic [5:0]  i_disp_src2_tag;
    logic [31:0] i_disp_src2_val;
    logic [5:0]  i_disp_dst_tag;
    logic [3:0]  i_disp_rob_idx;
    logic        i_cdb_vld;
    logic [5:0]  i_cdb_tag;
    logic [31:0] i_cdb_val;
    logic        o_iss_vld;
    logic        i_iss_rdy;
    logic        o_iss_sub_flag;
    logic [31:0] o_iss_a;
    logic [31:0] o_iss_b;
    logic [5:0]  o_iss_dst_tag;
    logic [3:0]  o_iss_rob_idx;
    logic [2:0]  o_count;

    typedef struct packed {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  dst;
        logic [3:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_act;
    exp_t m_exp;
    int   n_chk  = 0;
    int   n_fail = 0;

    rv32i_adder_issue_queue dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (i_flush),
        .i_disp_vld      (i_disp_vld),
        .o_disp_rdy      (o_disp_rdy),
        .i_disp_sub_flag (i_disp_sub_flag),
        .i_disp_src1_rdy (i_disp_src1_rdy),
        .i_disp_src1_tag (i_disp_src1_tag),
        .i_disp_src1_val (i_disp_src1_val),
        .i_disp_src2_rdy (i_disp_src2_rdy),
        .i_disp_src2_tag (i_disp_src2_tag),
        .i_disp_src2_val (i_disp_src2_val),
        .i_disp_dst_tag  (i_disp_dst_tag),
        .i_disp_rob_idx  (i_disp_rob_idx),
        .i_cdb_vld       (i_cdb_vld),
        .i_cdb_tag       (i_cdb_tag),
        .i_cdb_val       (i_cdb_val),
        .o_iss_vld       (o_iss_vld),
        .i_iss_rdy       (i_iss_rdy),
        .o_iss_sub_flag  (o_iss_sub_flag),
        .o_iss_a         (o_iss_a),
        .o_iss_b         (o_iss_b),
        .o_iss_dst_tag   (o_iss_dst_tag),
        .o_iss_rob_idx   (o_iss_rob_idx),
        .o_count         (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic sub, input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                            input logic [5:0] dst, input logic [3:0] rob);
        i_disp_vld      = 1'b1;
        i_disp_sub_flag = sub;
        i_disp_src1_rdy = r1;
        i_disp_src1_tag = t1;
        i_disp_src1_val = v1;
        i_disp_src2_rdy = r2;
        i_disp_src2_tag = t2;
        i_disp_src2_val = v2;
        i_disp_dst_tag  = dst;
        i_disp_rob_idx  = rob;
    endtask

    task automatic push(input logic sub, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] dst, input logic [3:0] rob);
        exp_t e;
        e = '{sub: sub, a: a, b: b, dst: dst, rob: rob};
        exp_q.push_back(e);
    endtask

    task automatic set_cdb(input logic [5:0] tag, input logic [31:0] val);
        i_cdb_vld = 1'b1;
        i_cdb_tag = tag;
        i_cdb_val = val;
    endtask

    // Every fired issue must match the next expected op, in order.
    always @(negedge clk) begin
        if (o_iss_vld && i_iss_rdy) begin
            n_chk++;
            m_act = '{sub: o_iss_sub_flag, a: o_iss_a, b: o_iss_b, dst: o_iss_dst_tag, rob: o_iss_rob_idx};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_issue: got sub=%0b a=0x%0h b=0x%0h dst=%0d rob=%0d, expected no issue",
                         m_act.sub, m_act.a, m_act.b, m_act.dst, m_act.rob);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_act !== m_exp) begin
                    n_fail++;
                    $display("FAIL sb_issue: got sub=%0b a=0x%0h b=0x%0h dst=%0d rob=%0d, expected sub=%0b a=0x%0h b=0x%0h dst=%0d rob=%0d",
                             m_act.sub, m_act.a, m_act.b, m_act.dst, m_act.rob,
                             m_exp.sub, m_exp.a, m_exp.b, m_exp.dst, m_exp.rob);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_iss_rdy = 1'b0;
        i_disp_vld = 1'b0; i_disp_sub_flag = 1'b0;
        i_disp_src1_rdy = 1'b0; i_disp_src1_tag = '0; i_disp_src1_val = '0;
        i_disp_src2_rdy = 1'b0; i_disp_src2_tag = '0; i_disp_src2_val = '0;
        i_disp_dst_tag = '0; i_disp_rob_idx = '0;
        i_cdb_vld = 1'b0; i_cdb_tag = '0; i_cdb_val = '0;

        // Reset state
        repeat (3) step();
        chk("rst_disp_rdy", 32'(o_disp_rdy), 0);
        chk("rst_iss_vld", 32'(o_iss_vld), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_iss_a", o_iss_a, 0);
        rst = 1'b0;
        #1 chk("post_rst_disp_rdy", 32'(o_disp_rdy), 1);

        // 1: ready add issues the cycle after dispatch
        step();
        i_iss_rdy = 1'b1;
        set_disp(0, 1, 0, 5, 1, 0, 7, 1, 1);
        push(0, 5, 7, 1, 1);
        #1 chk("t1_no_same_cycle_iss", 32'(o_iss_vld), 0);
        step();
        i_disp_vld = 1'b0;
        #1 chk("t1_iss_vld", 32'(o_iss_vld), 1);
        chk("t1_count_1", 32'(o_count), 1);
        chk("t1_a", o_iss_a, 5);
        chk("t1_b", o_iss_b, 7);
        step();
        #1 chk("t1_count_0", 32'(o_count), 0);
        chk("t1_idle_vld", 32'(o_iss_vld), 0);

        // 2: sub waits for src2 tag 9, woken by CDB
        set_disp(1, 1, 0, 20, 0, 9, 0, 2, 2);
        push(1, 20, 3, 2, 2);
        step();
        i_disp_vld = 1'b0;
        #1 chk("t2_wait_vld", 32'(o_iss_vld), 0);
        chk("t2_wait_count", 32'(o_count), 1);
        step();
        set_cdb(9, 3);
`ifdef RV32I_ISQ_CDB_BYPASS_EN
        #1 chk("t2_bypass_vld", 32'(o_iss_vld), 1);
        chk("t2_bypass_b", o_iss_b, 3);
`else
        #1 chk("t2_cdb_cycle_vld", 32'(o_iss_vld), 0);
`endif
        step();
        i_cdb_vld = 1'b0;
`ifdef RV32I_ISQ_CDB_BYPASS_EN
        #1 chk("t2_bypass_count", 32'(o_count), 0);
`else
        #1 chk("t2_woken_vld", 32'(o_iss_vld), 1);
        chk("t2_woken_b", o_iss_b, 3);
        chk("t2_woken_sub", 32'(o_iss_sub_flag), 1);
`endif
        step();
        #1 chk("t2_count_0", 32'(o_count), 0);

        // 3: fill, full blocks dispatch even while issuing, order preserved
        i_iss_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_disp(0, 1, 0, 32'(k + 1), 1, 0, 32'(k + 100), 6'(10 + k), 4'(4 + k));
            push(0, 32'(k + 1), 32'(k + 100), 6'(10 + k), 4'(4 + k));
            step();
        end
        i_disp_vld = 1'b0;
        #1 chk("t3_full_count", 32'(o_count), 4);
        chk("t3_full_disp_rdy", 32'(o_disp_rdy), 0);
        chk("t3_full_iss_vld", 32'(o_iss_vld), 1);
        i_iss_rdy = 1'b1;
        set_disp(0, 1, 0, 50, 1, 0, 60, 20, 8);
        push(0, 50, 60, 20, 8);
        #1 chk("t3_full_fire_disp_rdy", 32'(o_disp_rdy), 0);
        step();
        #1 chk("t3_count_after_blocked", 32'(o_count), 3);
        step();
        i_disp_vld = 1'b0;
        #1 chk("t3_count_disp_and_iss", 32'(o_count), 3);
        repeat (3) step();
        #1 chk("t3_drained", 32'(o_count), 0);

        // 4: middle entry ready issues first; slot-2 entry wakes while shifting down
        i_iss_rdy = 1'b0;
        set_disp(0, 0, 11, 0, 1, 0, 1, 3, 3);
        step();
        set_disp(0, 1, 0, 32'h30, 1, 0, 32'h40, 4, 4);
        step();
        set_disp(1, 1, 0, 32'h1000, 0, 12, 0, 5, 5);
        step();
        i_disp_vld = 1'b0;
        push(0, 32'h30, 32'h40, 4, 4);
        push(1, 32'h1000, 32'h100, 5, 5);
        push(0, 32'h200, 1, 3, 3);
        i_iss_rdy = 1'b1;
        set_cdb(12, 32'h100);
        #1 chk("t4_first_a", o_iss_a, 32'h30);
        chk("t4_count_3", 32'(o_count), 3);
        step();
        i_cdb_vld = 1'b0;
        #1 chk("t4_shift_vld", 32'(o_iss_vld), 1);
        chk("t4_shift_a", o_iss_a, 32'h1000);
        chk("t4_shift_b", o_iss_b, 32'h100);
        chk("t4_count_2", 32'(o_count), 2);
        step();
        set_cdb(11, 32'h200);
        #1 chk("t4_count_1", 32'(o_count), 1);
        step();
        i_cdb_vld = 1'b0;
        step();
        #1 chk("t4_count_0", 32'(o_count), 0);

        // 5: dispatch + issue + CDB hit on the new entry in one cycle
        i_iss_rdy = 1'b0;
        set_disp(0, 1, 0, 1, 1, 0, 2, 6, 6);
        push(0, 1, 2, 6, 6);
        step();
        i_disp_vld = 1'b0;
        #1 chk("t5_count_1", 32'(o_count), 1);
        i_iss_rdy = 1'b1;
        set_disp(0, 0, 20, 0, 1, 0, 5, 7, 7);
        set_cdb(20, 32'h77);
        push(0, 32'h77, 5, 7, 7);
        #1 chk("t5_disp_rdy", 32'(o_disp_rdy), 1);
        step();
        i_disp_vld = 1'b0;
        i_cdb_vld = 1'b0;
        #1 chk("t5_count_unchanged", 32'(o_count), 1);
        chk("t5_new_ready_vld", 32'(o_iss_vld), 1);
        chk("t5_new_ready_a", o_iss_a, 32'h77);
        step();
        #1 chk("t5_count_0", 32'(o_count), 0);

        // 6: flush with pending issue, then reset mid-fill
        i_iss_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_disp(0, 1, 0, 32'(k + 9), 1, 0, 1, 6'(30 + k), 4'(k));
            step();
        end
        i_disp_vld = 1'b0;
        #1 chk("t6_count_3", 32'(o_count), 3);
        chk("t6_pending_vld", 32'(o_iss_vld), 1);
        i_flush = 1'b1;
        i_iss_rdy = 1'b1;
        #1 chk("t6_flush_vld", 32'(o_iss_vld), 0);
        step();
        i_flush = 1'b0;
        #1 chk("t6_flush_count", 32'(o_count), 0);
        chk("t6_flush_vld_after", 32'(o_iss_vld), 0);
        i_iss_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_disp(1, 1, 0, 32'(k + 40), 1, 0, 2, 6'(40 + k), 4'(k));
            step();
        end
        i_disp_vld = 1'b0;
        rst = 1'b1;
        i_iss_rdy = 1'b1;
        #1 chk("t6_rst_vld", 32'(o_iss_vld), 0);
        chk("t6_rst_disp_rdy", 32'(o_disp_rdy), 0);
        chk("t6_rst_a", o_iss_a, 0);
        step();
        rst = 1'b0;
        #1 chk("t6_rst_count", 32'(o_count), 0);
        chk("t6_rst_vld_after", 32'(o_iss_vld), 0);
        step();
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
